rtc_calendar: RTL and testbench
===============================

Name: rtc_calendar

Overview:
- Parametrised timekeeping core; successor to the fixed seconds/minutes/hours counter in the watch top level.
- Adds a configurable tick prescaler, a full calendar (day/month/year with leap years), a valid/ready time-set port with range checking, and a 12/24-hour output mode.
- Outputs are binary fields; they feed the existing BCD converters and the LCD string block unchanged.

Parameters:
- TICK_DIV, 50000000, clk cycles per second; minimum 2; small values are used in simulation.
- YEAR_W, 7, year-offset width; year counts 0..99 (2000..2099).
- START_YEAR, 0, year offset loaded at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run_en  in  1  1 = time advances; 0 = prescaler frozen (hold)
- mode_12h  in  1  1 = hour output in 12-hour form
- set_valid  in  1  set request
- set_ready  out  1  set request can be accepted this cycle
- set_field  in  3  0 sec, 1 min, 2 hour (24h), 3 day, 4 month, 5 year; 6-7 illegal
- set_value  in  7  value to write
- set_err  out  1  one-cycle pulse: accepted request was rejected
- second  out  6  0..59
- minute  out  6  0..59
- hour  out  5  0..23, or 1..12 when mode_12h=1
- pm  out  1  1 when internal hour ≥ 12 (valid in both modes)
- day  out  5  1..31
- month  out  4  1..12
- year  out  YEAR_W  0..99
- sec_pulse  out  1  one-cycle pulse on each second increment
- midnight_pulse  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover

Behaviour:
- Reset (rst=1 at a clk edge):
  - Fields become 00:00:00, day 1, month 1, year START_YEAR.
  - Prescaler is cleared.
  - set_err, sec_pulse and midnight_pulse are 0; set_ready is 1.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run_en=1.
  - tick is asserted in the cycle the count equals TICK_DIV-1 and run_en=1; the count then wraps to 0.
  - run_en=0 holds the count without clearing it.
- Increment cascade, all fields updated at the same edge as the tick:
  - sec 59->0 carries into min; min 59->0 carries into hour; hour 23->0 carries into day.
  - day last_day->1 carries into month; month 12->1 carries into year; year 99->0 wraps with no carry out.
  - sec_pulse is registered, high for the cycle after the tick edge. midnight_pulse is asserted in that same cycle.
- last_day:
  - 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for 4, 6, 9, 11.
  - February: 29 when year[1:0]==0, otherwise 28 (exact for 2000..2099).
- Set handshake:
  - set_ready = ~tick.
  - Transfer occurs when set_valid & set_ready; exactly one write per transfer cycle.
  - When a tick and a set_valid coincide, the tick wins; the requester holds set_valid and the write lands on the next cycle.
- Range check (24h hour, 0..23). A request is rejected when:
  - sec or min > 59, or hour > 23;
  - day < 1 or day > last_day(current month, current year);
  - month < 1 or month > 12, or year > 99;
  - set_field is 6 or 7.
  - On reject: the addressed field is unchanged and set_err pulses for the cycle after transfer.
- Side effects of a good write:
  - A write to seconds also clears the prescaler, so the next tick is a full TICK_DIV later.
  - A month or year write that leaves day > new last_day clamps day to new last_day in the same cycle (e.g. 31 Mar -> set month 4 -> 30 Apr; 29 Feb 24 -> set year 25 -> 28 Feb).
- Hour presentation (combinational from internal 24h hour):
  - mode_12h=0: hour = internal.
  - mode_12h=1: internal 0 -> 12; 1..12 -> same; 13..23 -> internal-12.
- Reset mid-operation (including mid-handshake) discards any pending request; no set_err is issued.

Decomposition:
- Package rtc_pkg:
  - Field-code constants FLD_SEC..FLD_YEAR.
  - Field widths.
  - Pure function days_in_month(month, year) returning 5 bits.
- Sub-module rtc_prescaler (TICK_DIV, clk, rst, run_en, clr, tick).
- Calendar cascade, set logic and hour mapping stay in rtc_calendar.

Test Plan:
- Reset, TICK_DIV=4, run_en=1 for 40 cycles -> after reset 00:00:00 01/01/00; sec_pulse every 4th cycle; second=10 at end.
- Preload 23:59:59 31/12/99 via set port, one tick -> 00:00:00 01/01/00; midnight_pulse and sec_pulse high together for one cycle.
- Leap/non-leap: 28/02/24 23:59:59 + tick -> 29/02/24; 28/02/23 23:59:59 + tick -> 01/03/23; 29/02/24 + day carry -> 01/03/24.
- Rejects: set minute=60, day=31 in April, field=7 -> set_err pulse each time, fields unchanged. Month 4 written while day=31 -> day=30, no set_err.
- Collision: assert set_valid (sec=30) in the tick cycle -> set_ready=0 that cycle; write lands next cycle; second=30; the next tick occurs TICK_DIV cycles later.
- 12h mode: internal hours 0, 12, 13, 23 -> hour/pm = 12/0, 12/1, 1/1, 11/1; toggling run_en=0 freezes all fields and the prescaler.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared field codes, widths, set-request layout and month-length helper
// for the RTC calendar core.
package rtc_pkg;

  localparam int FLD_W  = 3;
  localparam int VAL_W  = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;

  localparam logic [FLD_W-1:0] FLD_SEC   = 3'd0;
  localparam logic [FLD_W-1:0] FLD_MIN   = 3'd1;
  localparam logic [FLD_W-1:0] FLD_HOUR  = 3'd2;
  localparam logic [FLD_W-1:0] FLD_DAY   = 3'd3;
  localparam logic [FLD_W-1:0] FLD_MONTH = 3'd4;
  localparam logic [FLD_W-1:0] FLD_YEAR  = 3'd5;

  typedef struct packed {
    logic [FLD_W-1:0] field;
    logic [VAL_W-1:0] value;
  } set_req_t;

  // Month length; every year divisible by 4 in 2000..2099 is a leap year.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] month,
                                                     input logic [6:0]       year);
    case (month)
      4'd2:                     return ((year & 7'd3) == 7'd0) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
      default:                  return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles while running.
module rtc_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run_en && (cnt == LAST);

  // Count while enabled, wrap on tick, hold when stopped, restart on clr.
  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (tick)   cnt <= '0;
    else if (run_en) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rtc_calendar.sv
// Timekeeping core: prescaled seconds tick, sec/min/hour/day/month/year
// cascade with leap years, range-checked set port and 12/24h hour view.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int YEAR_W     = 7,
  parameter int START_YEAR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  input  logic              mode_12h,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [FLD_W-1:0]  set_field,
  input  logic [VAL_W-1:0]  set_value,
  output logic              set_err,
  output logic [SEC_W-1:0]  second,
  output logic [MIN_W-1:0]  minute,
  output logic [HOUR_W-1:0] hour,
  output logic              pm,
  output logic [DAY_W-1:0]  day,
  output logic [MON_W-1:0]  month,
  output logic [YEAR_W-1:0] year,
  output logic              sec_pulse,
  output logic              midnight_pulse
);

  logic [SEC_W-1:0]  sec_q;
  logic [MIN_W-1:0]  min_q;
  logic [HOUR_W-1:0] hr_q;
  logic [DAY_W-1:0]  day_q;
  logic [MON_W-1:0]  mon_q;
  logic [YEAR_W-1:0] yr_q;

  logic tick, xfer, bad, clr_pre;
  logic sec_wrap, min_wrap, hr_wrap, day_wrap, mon_wrap, yr_wrap;
  logic [DAY_W-1:0] last_day, new_ld;
  logic [MON_W-1:0] mon_new;
  logic [6:0]       yr_new;
  set_req_t         req;

  assign req.field = set_field;
  assign req.value = set_value;

  // A tick always wins over a set request; the requester just holds valid.
  assign set_ready = ~tick;
  assign xfer      = set_valid & set_ready;
  assign clr_pre   = xfer & ~bad & (req.field == FLD_SEC);

  rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk    (clk),
    .rst    (rst),
    .run_en (run_en),
    .clr    (clr_pre),
    .tick   (tick)
  );

  assign last_day = days_in_month(mon_q, 7'(yr_q));

  // Month length after a pending month/year write, used to clamp the day.
  assign mon_new = (req.field == FLD_MONTH) ? req.value[MON_W-1:0] : mon_q;
  assign yr_new  = (req.field == FLD_YEAR)  ? req.value : 7'(yr_q);
  assign new_ld  = days_in_month(mon_new, yr_new);

  assign sec_wrap = (sec_q == 6'd59);
  assign min_wrap = (min_q == 6'd59);
  assign hr_wrap  = (hr_q == 5'd23);
  assign day_wrap = (day_q == last_day);
  assign mon_wrap = (mon_q == 4'd12);
  assign yr_wrap  = (yr_q == YEAR_W'(99));

  // Range check of the request against the current calendar.
  always_comb begin
    bad = 1'b0;
    case (req.field)
      FLD_SEC, FLD_MIN: bad = (req.value > 7'd59);
      FLD_HOUR:         bad = (req.value > 7'd23);
      FLD_DAY:          bad = (req.value == 7'd0) || (req.value > {2'b00, last_day});
      FLD_MONTH:        bad = (req.value == 7'd0) || (req.value > 7'd12);
      FLD_YEAR:         bad = (req.value > 7'd99);
      default:          bad = 1'b1;
    endcase
  end

  // Calendar state: tick cascade first, otherwise at most one field write.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
      day_q <= 5'd1;
      mon_q <= 4'd1;
      yr_q  <= YEAR_W'(START_YEAR);
    end else if (tick) begin
      sec_q <= sec_wrap ? '0 : sec_q + 1'b1;
      if (sec_wrap) begin
        min_q <= min_wrap ? '0 : min_q + 1'b1;
        if (min_wrap) begin
          hr_q <= hr_wrap ? '0 : hr_q + 1'b1;
          if (hr_wrap) begin
            day_q <= day_wrap ? 5'd1 : day_q + 1'b1;
            if (day_wrap) begin
              mon_q <= mon_wrap ? 4'd1 : mon_q + 1'b1;
              if (mon_wrap) yr_q <= yr_wrap ? '0 : yr_q + 1'b1;
            end
          end
        end
      end
    end else if (xfer && !bad) begin
      case (req.field)
        FLD_SEC:  sec_q <= req.value[SEC_W-1:0];
        FLD_MIN:  min_q <= req.value[MIN_W-1:0];
        FLD_HOUR: hr_q  <= req.value[HOUR_W-1:0];
        FLD_DAY:  day_q <= req.value[DAY_W-1:0];
        FLD_MONTH: begin
          mon_q <= req.value[MON_W-1:0];
          if (day_q > new_ld) day_q <= new_ld;
        end
        FLD_YEAR: begin
          yr_q <= YEAR_W'(req.value);
          if (day_q > new_ld) day_q <= new_ld;
        end
        default: ;
      endcase
    end
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_pulse      <= 1'b0;
      midnight_pulse <= 1'b0;
      set_err        <= 1'b0;
    end else begin
      sec_pulse      <= tick;
      midnight_pulse <= tick & sec_wrap & min_wrap & hr_wrap;
      set_err        <= xfer & bad;
    end
  end

  // 12-hour view: 0 shows as 12, 13..23 fold down by 12.
  always_comb begin
    hour = hr_q;
    if (mode_12h) begin
      if (hr_q == 5'd0)       hour = 5'd12;
      else if (hr_q > 5'd12)  hour = hr_q - 5'd12;
    end
  end

  assign pm     = (hr_q >= 5'd12);
  assign second = sec_q;
  assign minute = min_q;
  assign day    = day_q;
  assign month  = mon_q;
  assign year   = yr_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed bench for rtc_calendar with a 4-cycle prescaler.
module tb_rtc_calendar;
  import rtc_pkg::*;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, run_en, mode_12h, set_valid;
  logic       set_ready, set_err, pm, sec_pulse, midnight_pulse;
  logic [2:0] set_field;
  logic [6:0] set_value;
  logic [5:0] second, minute;
  logic [4:0] hour, day;
  logic [3:0] month;
  logic [6:0] year;

  int tests = 0;
  int fails = 0;

  rtc_calendar #(.TICK_DIV(TD), .YEAR_W(7), .START_YEAR(0)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_ready(set_ready), .set_field(set_field),
    .set_value(set_value), .set_err(set_err), .second(second), .minute(minute),
    .hour(hour), .pm(pm), .day(day), .month(month), .year(year),
    .sec_pulse(sec_pulse), .midnight_pulse(midnight_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] pk(input int h, input int m, input int s,
                                     input int d, input int mo, input int y);
    return {5'(h), 6'(m), 6'(s), 5'(d), 4'(mo), 7'(y)};
  endfunction

  logic [32:0] now;
  assign now = {hour, minute, second, day, month, year};

  // One write through the set port; callers keep run_en=0 so it is always ready.
  task automatic do_set(input logic [2:0] f, input int v, output logic err);
    @(negedge clk);
    set_valid = 1'b1; set_field = f; set_value = 7'(v);
    @(posedge clk); #1;
    set_valid = 1'b0;
    @(negedge clk);
    err = set_err;
  endtask

  task automatic wait_pulse(input int budget, output int cyc, output logic got);
    got = 1'b0; cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (sec_pulse) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    int np; logic bad_gap;
    rst = 1'b1; run_en = 1'b0; mode_12h = 1'b0; set_valid = 1'b0;
    set_field = '0; set_value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (now !== pk(0,0,0,1,1,0)) begin fails++; $display("FAIL reset_fields: got %h want %h", now, pk(0,0,0,1,1,0)); end
    rst = 1'b0;
    tests++; if ({set_ready, set_err, sec_pulse, midnight_pulse} !== 4'b1000) begin
      fails++; $display("FAIL reset_flags: got %b want 1000", {set_ready, set_err, sec_pulse, midnight_pulse}); end
    run_en = 1'b1; np = 0; bad_gap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (sec_pulse) begin np++; if ((i % TD) != TD - 1) bad_gap = 1'b1; end
    end
    run_en = 1'b0;
    tests++; if (np != 10 || bad_gap) begin fails++; $display("FAIL run_pulses: got %0d gap_err %0b want 10 gap_err 0", np, bad_gap); end
    tests++; if (now !== pk(0,0,10,1,1,0)) begin fails++; $display("FAIL run_second: got sec %0d want 10", second); end
  endtask

  task automatic test_rollover;
    logic e; int cyc; logic got;
    do_set(FLD_MONTH, 12, e); do_set(FLD_DAY, 31, e); do_set(FLD_YEAR, 99, e);
    do_set(FLD_HOUR, 23, e);  do_set(FLD_MIN, 59, e); do_set(FLD_SEC, 59, e);
    tests++; if (now !== pk(23,59,59,31,12,99)) begin fails++; $display("FAIL preload: got %h want %h", now, pk(23,59,59,31,12,99)); end
    run_en = 1'b1;
    wait_pulse(8, cyc, got);
    run_en = 1'b0;
    tests++; if (!got || cyc != TD) begin fails++; $display("FAIL roll_tick: got %0b after %0d want 1 after %0d", got, cyc, TD); end
    tests++; if (midnight_pulse !== 1'b1) begin fails++; $display("FAIL roll_midnight: got %b want 1", midnight_pulse); end
    tests++; if (now !== pk(0,0,0,1,1,0)) begin fails++; $display("FAIL roll_fields: got %h want %h", now, pk(0,0,0,1,1,0)); end
    @(negedge clk);
    tests++; if ({sec_pulse, midnight_pulse} !== 2'b00) begin fails++; $display("FAIL roll_pulse_width: got %b want 00", {sec_pulse, midnight_pulse}); end
  endtask

  task automatic test_leap;
    logic e; int cyc; logic got;
    do_set(FLD_YEAR, 24, e); do_set(FLD_MONTH, 2, e); do_set(FLD_DAY, 28, e);
    do_set(FLD_HOUR, 23, e); do_set(FLD_MIN, 59, e);  do_set(FLD_SEC, 59, e);
    run_en = 1'b1; wait_pulse(8, cyc, got); run_en = 1'b0;
    tests++; if (!got || now !== pk(0,0,0,29,2,24)) begin fails++; $display("FAIL leap_28feb24: got %h want %h", now, pk(0,0,0,29,2,24)); end
    do_set(FLD_YEAR, 23, e);
    tests++; if (day !== 5'd28) begin fails++; $display("FAIL clamp_year23: got day %0d want 28", day); end
    do_set(FLD_HOUR, 23, e); do_set(FLD_MIN, 59, e); do_set(FLD_SEC, 59, e);
    run_en = 1'b1; wait_pulse(8, cyc, got); run_en = 1'b0;
    tests++; if (!got || now !== pk(0,0,0,1,3,23)) begin fails++; $display("FAIL nonleap_28feb23: got %h want %h", now, pk(0,0,0,1,3,23)); end
    do_set(FLD_YEAR, 24, e); do_set(FLD_MONTH, 2, e); do_set(FLD_DAY, 29, e);
    do_set(FLD_HOUR, 23, e); do_set(FLD_MIN, 59, e);  do_set(FLD_SEC, 59, e);
    run_en = 1'b1; wait_pulse(8, cyc, got); run_en = 1'b0;
    tests++; if (!got || now !== pk(0,0,0,1,3,24)) begin fails++; $display("FAIL leap_29feb24: got %h want %h", now, pk(0,0,0,1,3,24)); end
  endtask

  task automatic test_reject;
    logic e;
    do_set(FLD_MIN, 60, e);
    tests++; if (e !== 1'b1 || minute !== 6'd0) begin fails++; $display("FAIL rej_min60: got err %b min %0d want 1 0", e, minute); end
    @(negedge clk);
    tests++; if (set_err !== 1'b0) begin fails++; $display("FAIL rej_err_width: got %b want 0", set_err); end
    do_set(FLD_MONTH, 4, e);
    do_set(FLD_DAY, 31, e);
    tests++; if (e !== 1'b1 || day !== 5'd1) begin fails++; $display("FAIL rej_apr31: got err %b day %0d want 1 1", e, day); end
    do_set(3'd7, 5, e);
    tests++; if (e !== 1'b1 || now !== pk(0,0,0,1,4,24)) begin fails++; $display("FAIL rej_fld7: got err %b %h want 1 %h", e, now, pk(0,0,0,1,4,24)); end
    do_set(FLD_YEAR, 100, e);
    tests++; if (e !== 1'b1 || year !== 7'd24) begin fails++; $display("FAIL rej_year100: got err %b year %0d want 1 24", e, year); end
    do_set(FLD_MONTH, 3, e); do_set(FLD_DAY, 31, e); do_set(FLD_MONTH, 4, e);
    tests++; if (e !== 1'b0 || day !== 5'd30 || month !== 4'd4) begin fails++; $display("FAIL clamp_apr: got err %b day %0d mon %0d want 0 30 4", e, day, month); end
    do_set(FLD_MONTH, 2, e);
    tests++; if (day !== 5'd29) begin fails++; $display("FAIL clamp_feb24: got day %0d want 29", day); end
    do_set(FLD_YEAR, 25, e);
    tests++; if (e !== 1'b0 || day !== 5'd28) begin fails++; $display("FAIL clamp_year25: got err %b day %0d want 0 28", e, day); end
  endtask

  task automatic test_collision;
    logic e; int cyc; logic got;
    do_set(FLD_SEC, 0, e);
    run_en = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    tests++; if (set_ready !== 1'b1) begin fails++; $display("FAIL coll_ready_pre: got %b want 1", set_ready); end
    @(posedge clk); @(negedge clk);
    tests++; if (set_ready !== 1'b0) begin fails++; $display("FAIL coll_ready_tick: got %b want 0", set_ready); end
    set_valid = 1'b1; set_field = FLD_SEC; set_value = 7'd30;
    @(negedge clk);
    tests++; if ({set_ready, sec_pulse} !== 2'b11 || second !== 6'd1) begin
      fails++; $display("FAIL coll_tick_wins: got rdy/pulse %b sec %0d want 11 1", {set_ready, sec_pulse}, second); end
    @(posedge clk); #1 set_valid = 1'b0;
    @(negedge clk);
    tests++; if (second !== 6'd30) begin fails++; $display("FAIL coll_write: got %0d want 30", second); end
    wait_pulse(8, cyc, got);
    run_en = 1'b0;
    tests++; if (!got || cyc != TD || second !== 6'd31) begin
      fails++; $display("FAIL coll_next_tick: got %0b after %0d sec %0d want 1 after %0d sec 31", got, cyc, second, TD); end
  endtask

  task automatic test_12h;
    logic e; int cyc, np; logic got;
    int          hin [5] = '{0, 12, 13, 23, 23};
    logic        m12 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0]  hexp[5] = '{{5'd12,1'b0}, {5'd12,1'b1}, {5'd1,1'b1}, {5'd11,1'b1}, {5'd23,1'b1}};
    for (int k = 0; k < 5; k++) begin
      do_set(FLD_HOUR, hin[k], e);
      mode_12h = m12[k]; #1;
      tests++; if ({hour, pm} !== hexp[k]) begin
        fails++; $display("FAIL hour12_%0d: got %0d/%b want %0d/%b", hin[k], hour, pm, hexp[k][5:1], hexp[k][0]); end
    end
    mode_12h = 1'b0;
    do_set(FLD_SEC, 5, e);
    run_en = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    run_en = 1'b0; np = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); @(negedge clk); if (sec_pulse) np++; end
    tests++; if (np != 0 || now !== pk(23,0,5,28,2,25)) begin fails++; $display("FAIL freeze: got pulses %0d %h want 0 %h", np, now, pk(23,0,5,28,2,25)); end
    run_en = 1'b1; wait_pulse(8, cyc, got); run_en = 1'b0;
    tests++; if (!got || cyc != 2 || second !== 6'd6) begin fails++; $display("FAIL freeze_resume: got %0b after %0d sec %0d want 1 after 2 sec 6", got, cyc, second); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    set_valid = 1'b1; set_field = 3'd7; set_value = 7'd1; rst = 1'b1;
    @(posedge clk); #1 set_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    tests++; if (set_err !== 1'b0 || set_ready !== 1'b1 || now !== pk(0,0,0,1,1,0)) begin
      fails++; $display("FAIL reset_mid: got err %b rdy %b %h want 0 1 %h", set_err, set_ready, now, pk(0,0,0,1,1,0)); end
    @(negedge clk);
    tests++; if (set_err !== 1'b0) begin fails++; $display("FAIL reset_mid_err: got %b want 0", set_err); end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_leap();
    test_reject();
    test_collision();
    test_12h();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
